// File: rtl/coord_smoother_if.sv
// Centroid in / smoothed target out bundle between the red-pixel detector and coord_smoother.
// The master side is the detector/consumer; the slave side is the smoother itself.
interface coord_smoother_if;
    logic [10:0] iX;
    logic [10:0] iY;
    logic        iVALID_COORD;
    logic        iFRAME_END;
    logic [10:0] oX;
    logic [10:0] oY;
    logic        oVALID;
    logic        oLOCKED;

    modport master (
        output iX, iY, iVALID_COORD, iFRAME_END,
        input  oX, oY, oVALID, oLOCKED
    );

    modport slave (
        input  iX, iY, iVALID_COORD, iFRAME_END,
        output oX, oY, oVALID, oLOCKED
    );
endinterface

// File: rtl/coord_smoother.sv
// Stabilises the detector centroid: moving average, single-frame outlier rejection
// with forced re-seed, and loss-of-lock after a run of frames without a centroid.
module coord_smoother #(
    parameter int AVG_LOG2     = 2,
    parameter int MAX_JUMP     = 64,
    parameter int REJECT_LIMIT = 3,
    parameter int LOST_FRAMES  = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    coord_smoother_if.slave   bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUMW  = 11 + AVG_LOG2;
    localparam int RW    = $clog2(REJECT_LIMIT + 1);
    localparam int MW    = $clog2(LOST_FRAMES + 1);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t            state_q, state_d;
    logic [10:0]       slotX_q [DEPTH];
    logic [10:0]       slotX_d [DEPTH];
    logic [10:0]       slotY_q [DEPTH];
    logic [10:0]       slotY_d [DEPTH];
    logic [SUMW-1:0]   sumX_q, sumX_d;
    logic [SUMW-1:0]   sumY_q, sumY_d;
    logic [AVG_LOG2-1:0] ptr_q, ptr_d;
    logic [RW-1:0]     rejCnt_q, rejCnt_d;
    logic [MW-1:0]     missCnt_q, missCnt_d;
    logic              seen_q, seen_d;
    logic [10:0]       outX_q, outX_d;
    logic [10:0]       outY_q, outY_d;
    logic              valid_q, valid_d;

    logic signed [11:0] diffX, diffY;
    logic [11:0]        dx, dy;
    logic               inRange;
    logic               doSeed, doAccept;

    // Distance from the current output, widened to 12 bits so the full 11-bit range is signed-safe.
    assign diffX   = $signed({1'b0, bus.iX}) - $signed({1'b0, outX_q});
    assign diffY   = $signed({1'b0, bus.iY}) - $signed({1'b0, outY_q});
    assign dx      = diffX[11] ? $unsigned(-diffX) : $unsigned(diffX);
    assign dy      = diffY[11] ? $unsigned(-diffY) : $unsigned(diffY);
    assign inRange = (dx <= 12'(MAX_JUMP)) && (dy <= 12'(MAX_JUMP));

    always_comb begin
        state_d   = state_q;
        slotX_d   = slotX_q;
        slotY_d   = slotY_q;
        sumX_d    = sumX_q;
        sumY_d    = sumY_q;
        ptr_d     = ptr_q;
        rejCnt_d  = rejCnt_q;
        missCnt_d = missCnt_q;
        seen_d    = seen_q;
        outX_d    = outX_q;
        outY_d    = outY_q;
        valid_d   = 1'b0;
        doSeed    = 1'b0;
        doAccept  = 1'b0;

        if (state_q == IDLE) begin
            doSeed = bus.iVALID_COORD;
        end else if (bus.iVALID_COORD) begin
            // A sample coincident with frame end belongs to the ending frame, so the next frame starts unseen.
            missCnt_d = '0;
            seen_d    = !bus.iFRAME_END;
            if (inRange) begin
                doAccept = 1'b1;
            end else if (rejCnt_q == RW'(REJECT_LIMIT - 1)) begin
                doSeed = 1'b1;
            end else begin
                rejCnt_d = rejCnt_q + RW'(1);
            end
        end else if (bus.iFRAME_END) begin
            seen_d = 1'b0;
            if (!seen_q) begin
                if (missCnt_q != MW'(LOST_FRAMES)) begin
                    missCnt_d = missCnt_q + MW'(1);
                end
                if (missCnt_q == MW'(LOST_FRAMES - 1)) begin
                    state_d = IDLE;
                end
            end
        end

        if (doSeed) begin
            for (int i = 0; i < DEPTH; i++) begin
                slotX_d[i] = bus.iX;
                slotY_d[i] = bus.iY;
            end
            sumX_d    = SUMW'(bus.iX) << AVG_LOG2;
            sumY_d    = SUMW'(bus.iY) << AVG_LOG2;
            ptr_d     = '0;
            rejCnt_d  = '0;
            missCnt_d = '0;
            seen_d    = !bus.iFRAME_END;
            state_d   = TRACK;
            outX_d    = bus.iX;
            outY_d    = bus.iY;
            valid_d   = 1'b1;
        end

        // Running sums swap the oldest slot for the new sample; the pointer wraps naturally.
        if (doAccept) begin
            slotX_d[ptr_q] = bus.iX;
            slotY_d[ptr_q] = bus.iY;
            sumX_d   = sumX_q - SUMW'(slotX_q[ptr_q]) + SUMW'(bus.iX);
            sumY_d   = sumY_q - SUMW'(slotY_q[ptr_q]) + SUMW'(bus.iY);
            ptr_d    = ptr_q + AVG_LOG2'(1);
            rejCnt_d = '0;
            outX_d   = 11'(sumX_d >> AVG_LOG2);
            outY_d   = 11'(sumY_d >> AVG_LOG2);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                slotX_q[i] <= '0;
                slotY_q[i] <= '0;
            end
            sumX_q    <= '0;
            sumY_q    <= '0;
            ptr_q     <= '0;
            rejCnt_q  <= '0;
            missCnt_q <= '0;
            seen_q    <= 1'b0;
            outX_q    <= '0;
            outY_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slotX_q   <= slotX_d;
            slotY_q   <= slotY_d;
            sumX_q    <= sumX_d;
            sumY_q    <= sumY_d;
            ptr_q     <= ptr_d;
            rejCnt_q  <= rejCnt_d;
            missCnt_q <= missCnt_d;
            seen_q    <= seen_d;
            outX_q    <= outX_d;
            outY_q    <= outY_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.oX      = outX_q;
    assign bus.oY      = outY_q;
    assign bus.oVALID  = valid_q;
    assign bus.oLOCKED = (state_q == TRACK);
endmodule

// File: tb/tb_coord_smoother.sv
// Directed bench for coord_smoother: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_coord_smoother;
    localparam int DEPTH = 4;
    localparam int MAXJ  = 64;
    localparam int RLIM  = 3;
    localparam int LOST  = 8;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    coord_smoother_if bus();

    coord_smoother #(
        .AVG_LOG2(2), .MAX_JUMP(MAXJ), .REJECT_LIMIT(RLIM), .LOST_FRAMES(LOST)
    ) dut (
        .iCLK(clock),
        .iRST(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: last DEPTH accepted samples, oldest first.
    int histX[$];
    int histY[$];
    int mOutX, mOutY, mRej, mMiss;
    bit mValid, mLocked, mSeen;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        histX = {};
        histY = {};
        mOutX = 0; mOutY = 0; mRej = 0; mMiss = 0;
        mValid = 0; mLocked = 0; mSeen = 0;
    endtask

    task automatic modelSeed(input int x, input int y, input bit fe);
        histX = {};
        histY = {};
        for (int i = 0; i < DEPTH; i++) begin
            histX.push_back(x);
            histY.push_back(y);
        end
        mOutX = x; mOutY = y; mValid = 1; mLocked = 1;
        mRej = 0; mMiss = 0; mSeen = !fe;
    endtask

    task automatic modelStep(input bit v, input int x, input int y, input bit fe);
        int dx, dy, sx, sy;
        mValid = 0;
        if (!mLocked) begin
            if (v) modelSeed(x, y, fe);
        end else if (v) begin
            mMiss = 0;
            mSeen = !fe;
            dx = x - mOutX; if (dx < 0) dx = -dx;
            dy = y - mOutY; if (dy < 0) dy = -dy;
            if (dx <= MAXJ && dy <= MAXJ) begin
                void'(histX.pop_front());
                void'(histY.pop_front());
                histX.push_back(x);
                histY.push_back(y);
                sx = 0; sy = 0;
                foreach (histX[i]) sx += histX[i];
                foreach (histY[i]) sy += histY[i];
                mOutX = sx / DEPTH;
                mOutY = sy / DEPTH;
                mValid = 1;
                mRej = 0;
            end else begin
                mRej++;
                if (mRej == RLIM) modelSeed(x, y, fe);
            end
        end else if (fe) begin
            if (!mSeen) begin
                if (mMiss < LOST) mMiss++;
                if (mMiss == LOST) mLocked = 0;
            end
            mSeen = 0;
        end
    endtask

    // Drive one cycle of input from a negedge, update the model at the capturing edge, return at the next negedge.
    task automatic applyStimulus(input bit v, input int x, input int y, input bit fe);
        bus.iVALID_COORD = v;
        bus.iX = 11'(x);
        bus.iY = 11'(y);
        bus.iFRAME_END = fe;
        @(posedge clock);
        modelStep(v, x, y, fe);
        @(negedge clock);
        bus.iVALID_COORD = 1'b0;
        bus.iFRAME_END = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        modelReset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                checkOutput("cmpX", int'(bus.oX), mOutX);
                checkOutput("cmpY", int'(bus.oY), mOutY);
                checkOutput("cmpValid", int'(bus.oVALID), int'(mValid));
                checkOutput("cmpLocked", int'(bus.oLOCKED), int'(mLocked));
            end
        end
    end

    int avgIn[4]  = '{104, 108, 112, 116};
    int avgExp[4] = '{101, 103, 106, 110};

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.iX = '0; bus.iY = '0;
        bus.iVALID_COORD = 1'b0; bus.iFRAME_END = 1'b0;
        modelReset();
        @(negedge clock);
        @(negedge clock);
        checkOutput("rstX", int'(bus.oX), 0);
        checkOutput("rstValid", int'(bus.oVALID), 0);
        checkOutput("rstLocked", int'(bus.oLOCKED), 0);
        reset = 1'b0;

        $display("[TB] seed and averaging");
        applyStimulus(1, 100, 200, 0);
        checkOutput("seedX", int'(bus.oX), 100);
        checkOutput("seedY", int'(bus.oY), 200);
        checkOutput("seedValid", int'(bus.oVALID), 1);
        checkOutput("seedLocked", int'(bus.oLOCKED), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("seedValidPulse", int'(bus.oVALID), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, avgIn[i], 200, 0);
            checkOutput("avgX", int'(bus.oX), avgExp[i]);
            checkOutput("avgY", int'(bus.oY), 200);
        end

        $display("[TB] outlier and re-seed");
        resetDut();
        applyStimulus(1, 100, 200, 0);
        applyStimulus(1, 104, 200, 0);
        applyStimulus(1, 108, 200, 0);
        applyStimulus(1, 112, 200, 0);
        checkOutput("preRejX", int'(bus.oX), 106);
        applyStimulus(1, 300, 200, 0);
        checkOutput("rej1Valid", int'(bus.oVALID), 0);
        checkOutput("rej1X", int'(bus.oX), 106);
        applyStimulus(1, 300, 200, 0);
        checkOutput("rej2X", int'(bus.oX), 106);
        applyStimulus(1, 300, 200, 0);
        checkOutput("reseedX", int'(bus.oX), 300);
        checkOutput("reseedValid", int'(bus.oVALID), 1);
        applyStimulus(1, 500, 200, 0);
        applyStimulus(1, 500, 200, 0);
        applyStimulus(1, 300, 200, 0);
        checkOutput("inRangeValid", int'(bus.oVALID), 1);
        applyStimulus(1, 500, 200, 0);
        applyStimulus(1, 500, 200, 0);
        checkOutput("noReseedValid", int'(bus.oVALID), 0);
        checkOutput("noReseedX", int'(bus.oX), 300);

        $display("[TB] jump boundary");
        resetDut();
        applyStimulus(1, 100, 200, 0);
        applyStimulus(1, 164, 200, 0);
        checkOutput("jump64Valid", int'(bus.oVALID), 1);
        checkOutput("jump64X", int'(bus.oX), 116);
        resetDut();
        applyStimulus(1, 100, 200, 0);
        applyStimulus(1, 165, 200, 0);
        checkOutput("jump65Valid", int'(bus.oVALID), 0);
        checkOutput("jump65X", int'(bus.oX), 100);
        applyStimulus(1, 100, 136, 0);
        checkOutput("jumpY64Valid", int'(bus.oVALID), 1);

        $display("[TB] loss of lock");
        resetDut();
        applyStimulus(1, 100, 200, 1);
        for (int i = 0; i < LOST - 1; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("miss7Locked", int'(bus.oLOCKED), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("miss8Locked", int'(bus.oLOCKED), 0);
        checkOutput("lostHoldX", int'(bus.oX), 100);
        checkOutput("lostHoldY", int'(bus.oY), 200);
        applyStimulus(0, 0, 0, 1);
        checkOutput("idleFrameLocked", int'(bus.oLOCKED), 0);
        applyStimulus(1, 50, 60, 0);
        checkOutput("relockX", int'(bus.oX), 50);
        checkOutput("relockLocked", int'(bus.oLOCKED), 1);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < LOST - 1; i++) applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 52, 60, 1);
        checkOutput("coincidentLocked", int'(bus.oLOCKED), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("afterCoincidentLocked", int'(bus.oLOCKED), 1);

        $display("[TB] async reset mid-operation");
        bus.iVALID_COORD = 1'b1;
        bus.iX = 11'd55;
        bus.iY = 11'd60;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncX", int'(bus.oX), 0);
        checkOutput("asyncY", int'(bus.oY), 0);
        checkOutput("asyncValid", int'(bus.oVALID), 0);
        checkOutput("asyncLocked", int'(bus.oLOCKED), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus.iVALID_COORD = 1'b0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 70, 80, 0);
        checkOutput("postRstX", int'(bus.oX), 70);
        checkOutput("postRstY", int'(bus.oY), 80);
        checkOutput("postRstLocked", int'(bus.oLOCKED), 1);
        applyStimulus(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/coord_smoother.md
Name: coord_smoother

Overview:
- Sits directly downstream of the red-pixel group detector. It consumes that stage's per-frame centroid (iX, iY, iVALID_COORD).
- Produces a stabilised target coordinate for the overlay and control logic.
- Three functions:
  - moving average over the last 2^AVG_LOG2 accepted centroids
  - outlier rejection for single-frame jumps
  - loss-of-target detection, counted in frames with no centroid

Parameters:
- AVG_LOG2, 2, log2 of averaging window depth (DEPTH = 2^AVG_LOG2, legal 1..4).
- MAX_JUMP, 64, max per-axis absolute difference from the current output for a sample to be accepted.
- REJECT_LIMIT, 3, number of consecutive rejected samples that forces a re-seed.
- LOST_FRAMES, 8, number of consecutive frames without a centroid before the lock is dropped.

Ports:
- iCLK  in  1  pixel clock, the same domain as the detector.
- iRST  in  1  reset; asynchronous, active-high.
- iX  in  11  centroid column from the detector.
- iY  in  11  centroid row from the detector.
- iVALID_COORD  in  1  one-cycle strobe; iX/iY are valid in this cycle.
- iFRAME_END  in  1  one-cycle strobe at the end of each frame.
- oX  out  11  smoothed column.
- oY  out  11  smoothed row.
- oVALID  out  1  one-cycle strobe; oX/oY were updated this cycle.
- oLOCKED  out  1  high while a target is being tracked.

Behaviour:
- Clock and reset:
  - Single clock domain: iCLK.
  - iRST is asynchronous and active-high. It clears all state immediately, including mid-frame or mid-update.
  - Reset values: oX=0, oY=0, oVALID=0, oLOCKED=0. Internally: state=IDLE, ring buffer all 0, sums 0, write pointer 0, reject count 0, miss count 0.
- Storage:
  - DEPTH-entry ring buffer per axis, plus running sums sumX and sumY.
  - Sum width is 11+AVG_LOG2 bits, so it never overflows.
  - oX = sumX >> AVG_LOG2 (truncating); oY likewise.
- Timing:
  - oX, oY and oVALID are registered. They update in the cycle after the accepted or re-seeding iVALID_COORD.
  - Latency is 1 cycle.
- FSM states: IDLE and TRACK.
- IDLE, on iVALID_COORD (seed):
  - Write the sample into all DEPTH slots.
  - sumX = iX<<AVG_LOG2; sumY likewise.
  - Pointer := 0, reject count := 0, miss count := 0.
  - Go to TRACK.
  - Next cycle: oX=iX, oY=iY, oVALID=1, oLOCKED=1.
- TRACK, on iVALID_COORD, compute dx=|iX-oX| and dy=|iY-oY| (12-bit unsigned compare).
  - Accept when dx<=MAX_JUMP and dy<=MAX_JUMP:
    - sum := sum - slot[ptr] + sample; slot[ptr] := sample.
    - Pointer increments and wraps DEPTH-1 -> 0.
    - Reject count := 0.
    - oVALID pulses next cycle.
  - Reject otherwise:
    - Reject count increments. Buffer, sums and outputs are unchanged; no oVALID.
    - When this rejection makes the count equal to REJECT_LIMIT, re-seed with this sample exactly as from IDLE (oVALID pulses) and set the reject count to 0.
- Miss counter:
  - Cleared by any iVALID_COORD, whether accepted or rejected.
  - Increments on each iFRAME_END for which no iVALID_COORD arrived since the previous iFRAME_END. It saturates at LOST_FRAMES.
  - iVALID_COORD and iFRAME_END in the same cycle: the sample belongs to the ending frame, and the miss counter goes to 0.
- Loss of lock:
  - In TRACK, when the miss counter reaches LOST_FRAMES, the FSM goes to IDLE and oLOCKED falls in the cycle after that iFRAME_END.
  - oX and oY hold their last values; no oVALID is issued.
  - The next iVALID_COORD seeds.
- IDLE:
  - The miss counter does not run.
  - iFRAME_END has no effect.
- oLOCKED is exactly (state==TRACK), registered.
- Other rules:
  - iX and iY are not range-checked.
  - Back-to-back iVALID_COORD strobes on consecutive cycles must each be processed; the design has 1-sample/cycle throughput.

Test Plan (defaults: DEPTH=4, MAX_JUMP=64, REJECT_LIMIT=3, LOST_FRAMES=8):
1. Reset and seed:
   - Stimulus: assert iRST, release, then iVALID_COORD with (100,200).
   - Required: all outputs are 0 during reset. One cycle after the strobe: oX=100, oY=200, oVALID=1 for exactly 1 cycle, oLOCKED=1.
2. Averaging and wrap:
   - Stimulus: after seed (100,200), send (104,200), (108,200), (112,200), (116,200), each as a single-cycle strobe.
   - Required: oX = 101, 103, 106, 110 in turn; oY=200 throughout. The pointer wrap is exercised on the 4th sample.
3. Outlier and re-seed:
   - Stimulus: while tracking at oX=106, send (300,200) three times.
   - Required: first two are rejected (no oVALID, oX stays 106). The third re-seeds: oX=300, oVALID=1.
   - Stimulus: repeat, with an in-range sample (106,200) sent between the rejects.
   - Required: the reject count is cleared, so no re-seed occurs.
4. Jump boundary:
   - Stimulus: from oX=100, send (164,200).
   - Required: accepted, oVALID=1.
   - Stimulus: from a fresh seed at 100, send (165,200).
   - Required: rejected.
5. Loss of lock:
   - Stimulus: in TRACK, 8 iFRAME_END pulses with no iVALID_COORD.
   - Required: oLOCKED falls 1 cycle after the 8th pulse; oX/oY hold.
   - Stimulus: 7 empty frames, then iVALID_COORD coincident with the 8th iFRAME_END.
   - Required: oLOCKED stays 1.
   - Stimulus: after loss of lock, send (50,60).
   - Required: seeds, oX=50.
6. Async reset mid-operation:
   - Stimulus: assert iRST between clock edges while in TRACK with a strobe pending.
   - Required: outputs go to 0 immediately with no clock edge. After release, the first sample seeds cleanly.
